// File: rtl/mem_dp_clr.sv
// mem_dp_clr: 1R1W register-file memory with a sequential clear engine.
//   Parameters: width (data bits), entries (any count >= 1), init_value (clear value).
//   Ports:
//     clk, rst_n             clock, asynchronous active-low reset
//     wr_en/wr_addr/wr_data  write port; out-of-range or busy writes are dropped
//     rd_en/rd_addr          read request; result one cycle later
//     rd_data/rd_valid       registered read data and its one-cycle strobe
//     clear_req              start a full clear from IDLE
//     busy                   clear engine walking the array; accesses ignored
//     par_inj/parity_err     only with MEM_DP_PARITY_EN: corrupt stored parity / read parity check
//   Optional feature macro: MEM_DP_PARITY_EN (per-entry even parity bit).
module mem_dp_clr #(
    parameter int width = 12,
    parameter int entries = 6,
    parameter logic [width-1:0] init_value = '0,
    localparam int addr_width = (entries > 1) ? $clog2(entries) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [addr_width-1:0] wr_addr,
    input  logic [width-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [addr_width-1:0] rd_addr,
    output logic [width-1:0]      rd_data,
    output logic                  rd_valid,
    input  logic                  clear_req,
    output logic                  busy
`ifdef MEM_DP_PARITY_EN
    ,
    input  logic                  par_inj,
    output logic                  parity_err
`endif
);
`ifdef MEM_DP_PARITY_EN
    localparam int mw = width + 1;
`else
    localparam int mw = width;
`endif
    localparam logic [addr_width:0]   entries_w = (addr_width + 1)'(entries);
    localparam logic [addr_width-1:0] last_ptr  = addr_width'(entries - 1);
    typedef enum logic {CLEAR, IDLE} state_t;
    state_t                state_q, state_d;
    logic [addr_width-1:0] clr_ptr_q, clr_ptr_d;
    logic [width-1:0]      rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [mw-1:0]         mem_q [0:entries-1];
    logic                  mem_we;
    logic [addr_width-1:0] mem_addr;
    logic [mw-1:0]         mem_wdata;
    logic [mw-1:0]         wr_word, init_word, rd_word;
    logic                  wr_ok, rd_in_range;
`ifdef MEM_DP_PARITY_EN
    logic                  parity_err_q, parity_err_d;
    assign wr_word   = {(^wr_data) ^ par_inj, wr_data};
    assign init_word = {^init_value, init_value};
`else
    assign wr_word   = wr_data;
    assign init_word = init_value;
`endif
    assign wr_ok       = (state_q == IDLE) && wr_en && ({1'b0, wr_addr} < entries_w);
    assign rd_in_range = {1'b0, rd_addr} < entries_w;
    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        rd_word    = '0;
        mem_we     = 1'b0;
        mem_addr   = clr_ptr_q;
        mem_wdata  = init_word;
        if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            clr_ptr_d = (clr_ptr_q == last_ptr) ? '0 : clr_ptr_q + addr_width'(1);
            state_d   = (clr_ptr_q == last_ptr) ? IDLE : CLEAR;
        end else begin
            // clear_req does not suppress this cycle's accesses
            state_d   = clear_req ? CLEAR : IDLE;
            mem_we    = wr_ok;
            mem_addr  = wr_addr;
            mem_wdata = wr_word;
            if (rd_en) begin
                rd_valid_d = 1'b1;
                // write-first bypass on a same-address in-range write
                rd_word    = !rd_in_range ? '0 :
                             (wr_ok && wr_addr == rd_addr) ? wr_word : mem_q[rd_addr];
                rd_data_d  = rd_word[width-1:0];
            end
        end
    end
`ifdef MEM_DP_PARITY_EN
    assign parity_err_d = rd_valid_d && (rd_word[width] != ^rd_word[width-1:0]);
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= CLEAR;
            clr_ptr_q    <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
`ifdef MEM_DP_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            clr_ptr_q    <= clr_ptr_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
`ifdef MEM_DP_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end
    // array has no reset; the clear engine initialises it
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_addr] <= mem_wdata;
    end
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = (state_q == CLEAR);
`ifdef MEM_DP_PARITY_EN
    assign parity_err = parity_err_q;
`endif
endmodule

// File: tb/tb_mem_dp_clr.sv
// tb_mem_dp_clr: directed table-driven bench for mem_dp_clr (width 12, entries 6).
module tb_mem_dp_clr;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [11:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [2:0]  rd_addr = '0;
    logic [11:0] rd_data;
    logic        rd_valid;
    logic        clear_req = 1'b0;
    logic        busy;
`ifdef MEM_DP_PARITY_EN
    logic        par_inj = 1'b0;
    logic        parity_err;
`endif
    int          n_pass = 0;
    int          n_total = 0;
    int          n_step = 0;

    typedef struct {
        logic        clr;
        logic        we;
        logic [2:0]  wa;
        logic [11:0] wd;
        logic        re;
        logic [2:0]  ra;
        logic        ev;
        logic [11:0] ed;
        logic        eb;
    } vec_t;

    vec_t tbl[$];

    mem_dp_clr #(.width(12), .entries(6), .init_value(12'h000)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .clear_req(clear_req), .busy(busy)
`ifdef MEM_DP_PARITY_EN
        , .par_inj(par_inj), .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic clr, logic we, logic [2:0] wa, logic [11:0] wd,
                                logic re, logic [2:0] ra, logic ev, logic [11:0] ed, logic eb);
        vec_t v;
        v.clr = clr; v.we = we; v.wa = wa; v.wd = wd;
        v.re = re; v.ra = ra; v.ev = ev; v.ed = ed; v.eb = eb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // drive one cycle of inputs, then check outputs just after the edge
    task automatic step(input vec_t v);
        clear_req = v.clr; wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
        rd_en = v.re; rd_addr = v.ra;
        @(posedge clk);
        #1;
        n_step++;
        chk($sformatf("step%0d busy", n_step), {11'b0, busy}, {11'b0, v.eb});
        chk($sformatf("step%0d rd_valid", n_step), {11'b0, rd_valid}, {11'b0, v.ev});
        chk($sformatf("step%0d rd_data", n_step), rd_data, v.ed);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, " busy"}, {11'b0, busy}, 12'd1);
        chk({nm, " rd_valid"}, {11'b0, rd_valid}, 12'd0);
        chk({nm, " rd_data"}, rd_data, 12'h000);
`ifdef MEM_DP_PARITY_EN
        chk({nm, " parity_err"}, {11'b0, parity_err}, 12'd0);
`endif
    endtask

    initial begin
        // reset and initial clear: busy for exactly 6 cycles, accesses dropped
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;
        for (int i = 1; i <= 6; i++) step(mk(0, 1, 3'd0, 12'hFFF, 1, 3'd0, 0, 12'h000, i < 6));

        // main function table, array all zero on entry
        for (int a = 0; a < 6; a++) tbl.push_back(mk(0, 0, 0, 0, 1, 3'(a), 1, 12'h000, 0));
        tbl.push_back(mk(0, 1, 3'd2, 12'hABC, 0, 3'd0, 0, 12'h000, 0));
        tbl.push_back(mk(0, 0, 3'd0, 12'h000, 1, 3'd2, 1, 12'hABC, 0));
        tbl.push_back(mk(0, 0, 3'd0, 12'h000, 0, 3'd2, 0, 12'hABC, 0));
        tbl.push_back(mk(0, 1, 3'd4, 12'h123, 1, 3'd4, 1, 12'h123, 0));
        tbl.push_back(mk(0, 1, 3'd6, 12'h555, 1, 3'd6, 1, 12'h000, 0));
        tbl.push_back(mk(0, 0, 3'd0, 12'h000, 1, 3'd4, 1, 12'h123, 0));
        tbl.push_back(mk(0, 1, 3'd3, 12'h7E1, 1, 3'd2, 1, 12'hABC, 0));
        tbl.push_back(mk(0, 0, 3'd0, 12'h000, 1, 3'd3, 1, 12'h7E1, 0));
        tbl.push_back(mk(0, 1, 3'd7, 12'h111, 1, 3'd7, 1, 12'h000, 0));
        tbl.push_back(mk(0, 0, 3'd0, 12'h000, 1, 3'd0, 1, 12'h000, 0));
        foreach (tbl[i]) step(tbl[i]);

        // fill with 0xFFF, then clear; the clear_req cycle's read still happens
        for (int a = 0; a < 6; a++) step(mk(0, 1, 3'(a), 12'hFFF, 0, 3'd0, 0, 12'h000, 0));
        step(mk(1, 0, 3'd0, 12'h000, 1, 3'd5, 1, 12'hFFF, 1));
        for (int i = 1; i <= 6; i++)
            step(mk(i == 2, 1, 3'd1, 12'hAAA, 1, 3'd1, 0, 12'hFFF, i < 6));
        for (int a = 0; a < 6; a++) step(mk(0, 0, 3'd0, 12'h000, 1, 3'(a), 1, 12'h000, 0));

        // async reset in the middle of a clear
        step(mk(0, 1, 3'd0, 12'h5A5, 0, 3'd0, 0, 12'h000, 0));
        step(mk(0, 0, 3'd0, 12'h000, 1, 3'd0, 1, 12'h5A5, 0));
        step(mk(1, 0, 3'd0, 12'h000, 0, 3'd0, 0, 12'h5A5, 1));
        step(mk(0, 0, 3'd0, 12'h000, 0, 3'd0, 0, 12'h5A5, 1));
        step(mk(0, 0, 3'd0, 12'h000, 0, 3'd0, 0, 12'h5A5, 1));
        rst_n = 1'b0;
        #1;
        chk_reset("midclear reset");
        #1;
        rst_n = 1'b1;
        for (int i = 1; i <= 6; i++) step(mk(0, 0, 3'd0, 12'h000, 1, 3'd0, 0, 12'h000, i < 6));
        step(mk(0, 0, 3'd0, 12'h000, 1, 3'd0, 1, 12'h000, 0));

`ifdef MEM_DP_PARITY_EN
        par_inj = 1'b1;
        step(mk(0, 1, 3'd1, 12'h001, 0, 3'd0, 0, 12'h000, 0));
        par_inj = 1'b0;
        step(mk(0, 0, 3'd0, 12'h000, 1, 3'd1, 1, 12'h001, 0));
        chk("parity injected", {11'b0, parity_err}, 12'd1);
        step(mk(0, 1, 3'd1, 12'h001, 0, 3'd0, 0, 12'h001, 0));
        chk("parity idle", {11'b0, parity_err}, 12'd0);
        step(mk(0, 0, 3'd0, 12'h000, 1, 3'd1, 1, 12'h001, 0));
        chk("parity clean", {11'b0, parity_err}, 12'd0);
        par_inj = 1'b1;
        step(mk(0, 1, 3'd2, 12'h003, 1, 3'd2, 1, 12'h003, 0));
        chk("parity bypass", {11'b0, parity_err}, 12'd1);
        par_inj = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
